// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared constants, state encoding and request-validation
//               helpers for the memory access controller.
// Revision    : 1.0
// ============================================================================
package mem_ctrl_pkg;

  // RV32 load/store width encodings carried in funct3
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Controller state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  // Fault cause codes reported alongside Fault
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  // Unsigned loads have no store counterpart, so bu/hu with a write is illegal
  function automatic logic f3_illegal(input logic [2:0] f3, input logic wr);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b0;
      F3_BU, F3_HU:     return wr;
      default:          return 1'b1;
    endcase
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_H, F3_HU: return lo[0];
      F3_W:        return (lo != 2'b00);
      default:     return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_controller_if
// Description : Pipeline-side request/response and memory-side handshake
//               signals of the memory access controller.
// Revision    : 1.0
// ============================================================================
interface mem_access_controller_if;
  // Pipeline side
  logic        ReqValid;
  logic        ReqWrite;
  logic [2:0]  Funct3;
  logic [31:0] Addr;
  logic [31:0] WriteBus;
  logic        Stall;
  logic        RespValid;
  logic [31:0] ReadDataM;
  logic        Fault;
  logic [1:0]  FaultCause;
  // Memory side
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [3:0]  MemBE;
  logic        MemReady;
  logic [31:0] MemRData;

  // Controller view
  modport slave (
    input  ReqValid, ReqWrite, Funct3, Addr, WriteBus, MemReady, MemRData,
    output Stall, RespValid, ReadDataM, Fault, FaultCause,
    output MemReq, MemWe, MemAddr, MemWData, MemBE
  );

  // Environment view (pipeline plus memory)
  modport master (
    output ReqValid, ReqWrite, Funct3, Addr, WriteBus, MemReady, MemRData,
    input  Stall, RespValid, ReadDataM, Fault, FaultCause,
    input  MemReq, MemWe, MemAddr, MemWData, MemBE
  );
endinterface
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Byte-lane steering for stores (data replication and byte
//               enables) and lane extraction/extension for loads.
// Revision    : 1.0
// ============================================================================
module mem_lane_align
  import mem_ctrl_pkg::*;
(
  input  wire logic [2:0]  funct3,
  input  wire logic [1:0]  addr_lo,
  input  wire logic [31:0] write_bus,
  input  wire logic [31:0] mem_rdata,
  output logic      [3:0]  byte_en,
  output logic      [31:0] wdata,
  output logic      [31:0] load_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign sel_byte = mem_rdata[{addr_lo, 3'b000} +: 8];
  assign sel_half = mem_rdata[{addr_lo[1], 4'b0000} +: 16];

  // Store path: replicate the source across all lanes, enable the addressed ones
  always_comb begin
    byte_en = 4'b1111;
    wdata   = write_bus;
    case (funct3[1:0])
      2'b00: begin
        byte_en = 4'b0001 << addr_lo;
        wdata   = {4{write_bus[7:0]}};
      end
      2'b01: begin
        byte_en = 4'b0011 << {addr_lo[1], 1'b0};
        wdata   = {2{write_bus[15:0]}};
      end
      default: begin
        byte_en = 4'b1111;
        wdata   = write_bus;
      end
    endcase
  end

  // Load path: pick the addressed lane and sign- or zero-extend it
  always_comb begin
    load_data = mem_rdata;
    case (funct3)
      F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   load_data = {24'h000000, sel_byte};
      F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
      F3_HU:   load_data = {16'h0000, sel_half};
      default: load_data = mem_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_controller.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_controller
// Description : Sequences one load/store per pipeline request onto a
//               variable-latency single-port memory, stalls the pipeline
//               until completion and turns bad requests or a hung memory
//               into a one-cycle fault.
// Revision    : 1.0
// ============================================================================
module mem_access_controller
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  wire logic              clk,
  input  wire logic              reset,
  mem_access_controller_if.slave bus
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] BUSY  = ST_BUSY;
  localparam logic [1:0] DONE  = ST_DONE;
  localparam logic [1:0] FAULT = ST_FAULT;

  logic [1:0]    state;
  logic [2:0]    lat_f3;
  logic [1:0]    lat_lo;
  logic          lat_write;
  logic [CW-1:0] wait_cnt;

  logic [2:0]    align_f3;
  logic [1:0]    align_lo;
  logic [3:0]    align_be;
  logic [31:0]   align_wdata;
  logic [31:0]   align_load;
  logic          req_illegal;
  logic          req_misaligned;
  logic          timeout_hit;

  // Lanes come from the live request while accepting it, from the latch after
  assign align_f3 = (state == IDLE) ? bus.Funct3    : lat_f3;
  assign align_lo = (state == IDLE) ? bus.Addr[1:0] : lat_lo;

  assign req_illegal    = f3_illegal(bus.Funct3, bus.ReqWrite);
  assign req_misaligned = f3_misaligned(bus.Funct3, bus.Addr[1:0]);
  // The last permitted wait cycle is the one where the counter reads TIMEOUT-1
  assign timeout_hit    = (wait_cnt == CW'(TIMEOUT - 1));

  mem_lane_align u_align (
    .funct3    (align_f3),
    .addr_lo   (align_lo),
    .write_bus (bus.WriteBus),
    .mem_rdata (bus.MemRData),
    .byte_en   (align_be),
    .wdata     (align_wdata),
    .load_data (align_load)
  );

  // Request FSM with registered memory-side outputs and watchdog
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      lat_f3         <= 3'b000;
      lat_lo         <= 2'b00;
      lat_write      <= 1'b0;
      wait_cnt       <= '0;
      bus.MemReq     <= 1'b0;
      bus.MemWe      <= 1'b0;
      bus.MemAddr    <= 32'h0;
      bus.MemWData   <= 32'h0;
      bus.MemBE      <= 4'b0000;
      bus.ReadDataM  <= 32'h0;
      bus.FaultCause <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ReqValid) begin
            if (req_illegal) begin
              state          <= FAULT;
              bus.FaultCause <= CAUSE_ILLEGAL;
            end else if (req_misaligned) begin
              state          <= FAULT;
              bus.FaultCause <= CAUSE_MISALIGN;
            end else begin
              state        <= BUSY;
              lat_f3       <= bus.Funct3;
              lat_lo       <= bus.Addr[1:0];
              lat_write    <= bus.ReqWrite;
              wait_cnt     <= '0;
              bus.MemReq   <= 1'b1;
              bus.MemWe    <= bus.ReqWrite;
              bus.MemAddr  <= {bus.Addr[31:2], 2'b00};
              bus.MemWData <= bus.ReqWrite ? align_wdata : 32'h0;
              bus.MemBE    <= bus.ReqWrite ? align_be : 4'b0000;
            end
          end
        end
        BUSY: begin
          // A ready in the final permitted cycle still wins over the timeout
          if (bus.MemReady) begin
            state         <= DONE;
            bus.ReadDataM <= lat_write ? 32'h0 : align_load;
            bus.MemReq    <= 1'b0;
            bus.MemWe     <= 1'b0;
            bus.MemBE     <= 4'b0000;
          end else if (timeout_hit) begin
            state          <= FAULT;
            bus.FaultCause <= CAUSE_TIMEOUT;
            bus.MemReq     <= 1'b0;
            bus.MemWe      <= 1'b0;
            bus.MemBE      <= 4'b0000;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        FAULT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stall is gated by reset so every output is quiet while reset is held
  assign bus.Stall     = ~reset & (((state == IDLE) & bus.ReqValid) | (state == BUSY));
  assign bus.RespValid = (state == DONE);
  assign bus.Fault     = (state == FAULT);

endmodule
`default_nettype wire

// File: tb/tb_mem_access_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_controller
// Description : Scoreboard bench for mem_access_controller with a
//               programmable-latency memory responder.
// Revision    : 1.0
// ============================================================================
module tb_mem_access_controller;

  typedef struct {
    string       name;
    bit          is_fault;
    logic [1:0]  cause;
    bit          chk_data;
    logic [31:0] data;
  } resp_t;

  typedef struct {
    string       name;
    logic [31:0] addr;
    bit          we;
    logic [3:0]  be;
    bit          chk_wdata;
    logic [31:0] wdata;
  } memx_t;

  logic clk;
  logic reset;
  mem_access_controller_if mif();

  int    total = 0;
  int    bad   = 0;
  resp_t resp_q[$];
  memx_t mem_q[$];
  resp_t mon_r;
  memx_t mon_m;

  int          mem_wait  = 0;
  bit          mem_hang  = 0;
  logic [31:0] mem_rdata = 32'h0;
  int          wcnt      = 0;
  bit          prev_req  = 0;
  int          req_cycles = 0;

  mem_access_controller #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic exp_ok(input string nm, input bit cd, input logic [31:0] d);
    resp_t r;
    r.name = nm; r.is_fault = 0; r.cause = 2'b00; r.chk_data = cd; r.data = d;
    resp_q.push_back(r);
  endtask

  task automatic exp_fault(input string nm, input logic [1:0] c);
    resp_t r;
    r.name = nm; r.is_fault = 1; r.cause = c; r.chk_data = 0; r.data = 32'h0;
    resp_q.push_back(r);
  endtask

  task automatic exp_mem(input string nm, input logic [31:0] a, input bit we,
                         input logic [3:0] be, input logic [31:0] wd);
    memx_t m;
    m.name = nm; m.addr = a; m.we = we; m.be = be; m.chk_wdata = we; m.wdata = wd;
    mem_q.push_back(m);
  endtask

  // Memory responder: ready after mem_wait wait cycles of an active request
  always @(negedge clk) begin
    if (mif.MemReq && !mem_hang) begin
      if (wcnt == mem_wait) begin
        mif.MemReady = 1'b1;
        mif.MemRData = mem_rdata;
        wcnt = 0;
      end else begin
        mif.MemReady = 1'b0;
        wcnt++;
      end
    end else begin
      mif.MemReady = 1'b0;
      wcnt = 0;
    end
  end

  // Response and memory-access monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (mif.RespValid || mif.Fault) begin
        if (resp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_resp actual=resp/fault required=none");
        end else begin
          mon_r = resp_q.pop_front();
          chk({mon_r.name, "_fault"}, {31'h0, mif.Fault}, {31'h0, mon_r.is_fault});
          chk({mon_r.name, "_stall_low"}, {31'h0, mif.Stall}, 32'h0);
          if (mon_r.is_fault)
            chk({mon_r.name, "_cause"}, {30'h0, mif.FaultCause}, {30'h0, mon_r.cause});
          if (mon_r.chk_data)
            chk({mon_r.name, "_rdata"}, mif.ReadDataM, mon_r.data);
        end
      end
      if (mif.MemReq) begin
        req_cycles++;
        if (!prev_req) begin
          if (mem_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_memreq actual=addr %h required=none", mif.MemAddr);
          end else begin
            mon_m = mem_q.pop_front();
            chk({mon_m.name, "_maddr"}, mif.MemAddr, mon_m.addr);
            chk({mon_m.name, "_mwe"}, {31'h0, mif.MemWe}, {31'h0, mon_m.we});
            chk({mon_m.name, "_mbe"}, {28'h0, mif.MemBE}, {28'h0, mon_m.be});
            if (mon_m.chk_wdata)
              chk({mon_m.name, "_mwdata"}, mif.MemWData, mon_m.wdata);
          end
        end
      end
    end
    prev_req = mif.MemReq;
  end

  // Drive one request, count its stall cycles, optionally keep ReqValid high
  task automatic issue(input string nm, input bit wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wb,
                       input int exp_stall, input bit keep);
    int  n;
    bit  seen;
    bit  ended;
    n = 0; seen = 0; ended = 0;
    mif.ReqValid = 1'b1;
    mif.ReqWrite = wr;
    mif.Funct3   = f3;
    mif.Addr     = a;
    mif.WriteBus = wb;
    for (int k = 0; k < 40; k++) begin
      #2;
      if (mif.Stall) begin
        n++; seen = 1;
      end else if (seen) begin
        ended = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ended) begin
      total++; bad++;
      $display("FAIL %s_timeout actual=no_completion required=completion", nm);
    end
    chk({nm, "_stall_cycles"}, n, exp_stall);
    if (!keep) mif.ReqValid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=hung required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    mif.ReqValid = 1'b0;
    mif.ReqWrite = 1'b0;
    mif.Funct3   = 3'b000;
    mif.Addr     = 32'h0;
    mif.WriteBus = 32'h0;
    mif.MemReady = 1'b0;
    mif.MemRData = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall",  {31'h0, mif.Stall},     32'h0);
    chk("rst_resp",   {31'h0, mif.RespValid}, 32'h0);
    chk("rst_fault",  {31'h0, mif.Fault},     32'h0);
    chk("rst_memreq", {31'h0, mif.MemReq},    32'h0);
    chk("rst_rdata",  mif.ReadDataM,          32'h0);
    chk("rst_cause",  {30'h0, mif.FaultCause}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // sb at byte 3, zero-wait
    mem_wait = 0;
    exp_mem("sb", 32'h1000, 1, 4'b1000, 32'hA5A5A5A5);
    exp_ok("sb", 0, 32'h0);
    issue("sb", 1, 3'b000, 32'h1003, 32'h000000A5, 2, 0);
    @(negedge clk);

    // lh / lhu upper half, 3 wait cycles (ready lands on the last allowed cycle)
    mem_wait = 3; mem_rdata = 32'h80011234;
    exp_mem("lh", 32'h2000, 0, 4'b0000, 32'h0);
    exp_ok("lh", 1, 32'hFFFF8001);
    issue("lh", 0, 3'b001, 32'h2002, 32'h0, 5, 0);
    @(negedge clk);
    exp_mem("lhu", 32'h2000, 0, 4'b0000, 32'h0);
    exp_ok("lhu", 1, 32'h00008001);
    issue("lhu", 0, 3'b101, 32'h2002, 32'h0, 5, 0);
    @(negedge clk);

    // sh upper half and lb sign extension
    mem_wait = 1; mem_rdata = 32'h80000000;
    exp_mem("sh", 32'h0000, 1, 4'b1100, 32'hBEEFBEEF);
    exp_ok("sh", 0, 32'h0);
    issue("sh", 1, 3'b001, 32'h0002, 32'h1234BEEF, 3, 0);
    @(negedge clk);
    exp_mem("lb", 32'h0004, 0, 4'b0000, 32'h0);
    exp_ok("lb", 1, 32'hFFFFFF80);
    issue("lb", 0, 3'b000, 32'h0007, 32'h0, 3, 0);
    @(negedge clk);

    // Rejected requests: no memory access expected
    exp_fault("sw_mis", 2'b01);
    issue("sw_mis", 1, 3'b010, 32'h0006, 32'h11111111, 1, 0);
    @(negedge clk);
    exp_fault("sbu", 2'b10);
    issue("sbu", 1, 3'b100, 32'h0000, 32'h0, 1, 0);
    @(negedge clk);
    exp_fault("lh_mis", 2'b01);
    issue("lh_mis", 0, 3'b001, 32'h1001, 32'h0, 1, 0);
    @(negedge clk);
    exp_fault("f3_011_prio", 2'b10);
    issue("f3_011_prio", 0, 3'b011, 32'h0003, 32'h0, 1, 0);
    @(negedge clk);

    // Hung memory: MemReq for exactly 4 cycles, then timeout fault
    mem_hang = 1; req_cycles = 0;
    exp_mem("tmo", 32'h0040, 0, 4'b0000, 32'h0);
    exp_fault("tmo", 2'b11);
    issue("tmo", 0, 3'b010, 32'h0040, 32'h0, 5, 0);
    chk("tmo_req_cycles", req_cycles, 4);
    chk("tmo_memreq_low", {31'h0, mif.MemReq}, 32'h0);
    mem_hang = 0;
    @(negedge clk);

    // Reset on the second BUSY cycle abandons the access
    mem_wait = 10;
    exp_mem("rstb", 32'h0020, 0, 4'b0000, 32'h0);
    mif.ReqValid = 1'b1; mif.ReqWrite = 1'b0; mif.Funct3 = 3'b010;
    mif.Addr = 32'h0020; mif.WriteBus = 32'h0;
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("rstb_busy_memreq", {31'h0, mif.MemReq}, 32'h1);
    reset = 1'b1;
    #1;
    chk("rstb_memreq", {31'h0, mif.MemReq}, 32'h0);
    chk("rstb_stall",  {31'h0, mif.Stall},  32'h0);
    chk("rstb_be_we",  {27'h0, mif.MemBE, mif.MemWe}, 32'h0);
    chk("rstb_maddr",  mif.MemAddr,  32'h0);
    chk("rstb_rdata",  mif.ReadDataM, 32'h0);
    chk("rstb_cause",  {30'h0, mif.FaultCause}, 32'h0);
    mif.ReqValid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mem_wait = 0; mem_rdata = 32'hDEADBEEF;
    exp_mem("lw", 32'h0010, 0, 4'b0000, 32'h0);
    exp_ok("lw", 1, 32'hDEADBEEF);
    issue("lw", 0, 3'b010, 32'h0010, 32'h0, 2, 0);
    @(negedge clk);

    // Back-to-back sw then lbu with ReqValid held continuously
    mem_wait = 0; mem_rdata = 32'h0000CC00;
    exp_mem("b2b_sw", 32'h0008, 1, 4'b1111, 32'h12345678);
    exp_ok("b2b_sw", 0, 32'h0);
    exp_mem("b2b_lbu", 32'h0004, 0, 4'b0000, 32'h0);
    exp_ok("b2b_lbu", 1, 32'h000000CC);
    issue("b2b_sw", 1, 3'b010, 32'h0008, 32'h12345678, 2, 1);
    issue("b2b_lbu", 0, 3'b100, 32'h0005, 32'h0, 2, 0);
    repeat (3) @(negedge clk);

    chk("resp_q_drained", resp_q.size(), 0);
    chk("mem_q_drained", mem_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_controller.md
# mem_access_controller

Sequencing controller between the RV32IM memory stage and a single-ported, variable-latency data memory. It accepts one load or store per pipeline request and validates alignment and funct3. It drives a request/ready handshake to memory with byte-lane data and byte enables, and stalls the pipeline until the access completes. Load data is returned zero- or sign-extended, and a watchdog converts a hung memory into a fault.

## Interface
- TIMEOUT, 255: max cycles MemReq may wait for MemReady before a timeout fault; legal range 1..65535.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- ReqValid  in  1  memory-stage request present; held stable while Stall=1.
- ReqWrite  in  1  1=store, 0=load.
- Funct3  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu.
- Addr  in  32  byte address.
- WriteBus  in  32  store source register value.
- Stall  out  1  holds the pipeline.
- RespValid  out  1  one-cycle pulse when the access completes successfully.
- ReadDataM  out  32  extended load data, valid while RespValid=1 (load).
- Fault  out  1  one-cycle pulse when a request is rejected or times out.
- FaultCause  out  2  01 misaligned, 10 illegal funct3, 11 timeout; valid with Fault.
- MemReq  out  1  memory request, held until MemReady.
- MemWe  out  1  write strobe.
- MemAddr  out  32  {Addr[31:2], 2'b00}.
- MemWData  out  32  lane-replicated store data.
- MemBE  out  4  byte enables (all 0 on loads).
- MemReady  in  1  memory completion; sampled only while MemReq=1.
- MemRData  in  32  read word, valid with MemReady.

## Operation
- States: IDLE, BUSY, DONE, FAULT; one-hot or binary at implementer's choice.
- IDLE with ReqValid=1:
  - Legal request: latch Addr, Funct3, ReqWrite and WriteBus, then go to BUSY.
  - Illegal Funct3 (011, 110, 111, or 100/101 with ReqWrite=1): go to FAULT with cause 10.
  - Misaligned (h/hu with Addr[0]=1; w with Addr[1:0]≠00): go to FAULT with cause 01.
  - Illegal funct3 takes priority over misaligned.
- BUSY:
  - MemReq=1, with all Mem* outputs driven from latched registers.
  - Timeout counter clears on BUSY entry and increments each BUSY cycle without MemReady.
  - MemReady=1: capture and extend the load data, go to DONE.
  - Counter reaching TIMEOUT with MemReady=0: drop MemReq, go to FAULT with cause 11.
  - MemReady in the same cycle the counter hits TIMEOUT completes normally.
- DONE: RespValid=1, go to IDLE.
- FAULT: Fault=1, go to IDLE; no memory access is issued for a rejected request.
- Stall = (state==IDLE & ReqValid) | (state==BUSY). Stall is low in DONE and FAULT, so the pipeline advances exactly once per request.
- Store lanes:
  - sb: MemWData={4{WriteBus[7:0]}}, MemBE=0001<<Addr[1:0].
  - sh: MemWData={2{WriteBus[15:0]}}, MemBE=0011<<{Addr[1],0}.
  - sw: MemWData=WriteBus, MemBE=1111.
- Load extraction:
  - byte = MemRData[8*Addr[1:0] +: 8]; half = MemRData[16*Addr[1] +: 16].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- Reset:
  - All state returns to IDLE and every output goes to 0, including ReadDataM and FaultCause.
  - Reset mid-BUSY abandons the access; memory must tolerate MemReq dropping without MemReady.

## Timing
- Zero-wait memory (MemReady high on the first BUSY cycle):
  - Cycle 0: IDLE, request accepted.
  - Cycle 1: BUSY.
  - Cycle 2: DONE.
  - Stall is high for 2 cycles; total latency is 3 cycles.
- Each cycle of memory wait adds one BUSY cycle.
- Rejected request: Stall high 1 cycle (IDLE), then the FAULT cycle.
- Mem* outputs are registered and change only on the IDLE→BUSY edge and on BUSY exit.
- ReqValid/Addr changes while Stall=1 are a protocol violation; latched values are used.

## Structure
- Package mem_ctrl_pkg:
  - Funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum.
  - Fault cause constants.
- Sub-module mem_lane_align (combinational):
  - MemBE and MemWData generation from {Funct3, Addr[1:0], WriteBus}.
  - Load extraction/extension from {Funct3, Addr[1:0], MemRData}.
- Top: FSM, latch registers, timeout counter (width $clog2(TIMEOUT+1)).

## Test plan
- sb, Addr=0x1003, WriteBus=0x000000A5, zero-wait: MemBE=1000, MemWData=0xA5A5A5A5, MemAddr=0x1000, RespValid in cycle 2, Stall high 2 cycles.
- lh, Addr=0x2002, MemRData=0x8001_1234, 3 wait cycles: ReadDataM=0xFFFF8001; lhu same case gives 0x00008001; Stall high for 5 cycles.
- sw, Addr=0x0006: Fault=1 with cause 01 in cycle 1, MemReq never asserted; sbu (Funct3=100 with ReqWrite=1): cause 10.
- TIMEOUT=4, MemReady held 0: MemReq high for exactly 4 cycles, then Fault with cause 11, Stall low, back to IDLE.
- Reset asserted on the second BUSY cycle: MemReq, Stall and all outputs go to 0 immediately; after release, a new lw Addr=0x10 with MemRData=0xDEADBEEF returns 0xDEADBEEF.
- Back-to-back sw then lbu (Addr=0x5, MemRData=0x0000CC00), ReqValid continuous: two separate accesses, one RespValid each, ReadDataM=0x000000CC.
